pixel_quad_packer: RTL



---
 rtl/pixel_quad_packer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pixel_quad_packer.sv
// ============================================================================
// Module   : pixel_quad_packer
// Purpose  : Packs single RGB pixels into MSB-first quads with line flush.
//            Optional PACKER_COUNT_EN adds quad/line handshake counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_quad_packer #(
  parameter int               PIX_W     = 8,
  parameter logic [PIX_W-1:0] PAD_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_pix,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     R,
  input  logic [PIX_W-1:0]     G,
  input  logic [PIX_W-1:0]     B,
  input  logic                 pix_last,
  output logic                 valid_quad,
  input  logic                 quad_ready,
  output logic [4*PIX_W-1:0]   R_quad,
  output logic [4*PIX_W-1:0]   G_quad,
  output logic [4*PIX_W-1:0]   B_quad,
  output logic [3:0]           quad_mask,
  output logic                 quad_last
`ifdef PACKER_COUNT_EN
  ,
  output logic [15:0]          quad_count,
  output logic [15:0]          line_count
`endif
);

  localparam int QUAD_W = 4 * PIX_W;
  localparam int ACC_W  = 3 * PIX_W;

  function automatic logic [QUAD_W-1:0] put_slot(input logic [QUAD_W-1:0] w,
                                                 input logic [1:0]        s,
                                                 input logic [PIX_W-1:0]  p);
    logic [QUAD_W-1:0] res;
    res = w;
    res[QUAD_W-1-int'(s)*PIX_W -: PIX_W] = p;
    return res;
  endfunction

  logic [1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]  acc_r_q, acc_g_q, acc_b_q;
  logic [ACC_W-1:0]  acc_r_d, acc_g_d, acc_b_d;
  logic [QUAD_W-1:0] out_r_q, out_g_q, out_b_q;
  logic [QUAD_W-1:0] out_r_d, out_g_d, out_b_d;
  logic [3:0]        mask_q, mask_d;
  logic              last_q, last_d;
  logic              vq_q, vq_d;

  logic              accept;
  logic              complete;
  logic [QUAD_W-1:0] merged_r, merged_g, merged_b;

  assign pix_ready = !vq_q || quad_ready;
  assign accept    = valid_pix && pix_ready;
  assign complete  = accept && ((idx_q == 2'd3) || pix_last);

  // Unwritten accumulator slots already hold PAD_VALUE, so merging the
  // current pixel at idx yields the padded quad directly.
  assign merged_r = put_slot({acc_r_q, PAD_VALUE}, idx_q, R);
  assign merged_g = put_slot({acc_g_q, PAD_VALUE}, idx_q, G);
  assign merged_b = put_slot({acc_b_q, PAD_VALUE}, idx_q, B);

  always_comb begin
    idx_d   = idx_q;
    acc_r_d = acc_r_q;
    acc_g_d = acc_g_q;
    acc_b_d = acc_b_q;
    out_r_d = out_r_q;
    out_g_d = out_g_q;
    out_b_d = out_b_q;
    mask_d  = mask_q;
    last_d  = last_q;
    vq_d    = vq_q;

    if (vq_q && quad_ready) begin
      vq_d = 1'b0;
    end

    if (complete) begin
      out_r_d = merged_r;
      out_g_d = merged_g;
      out_b_d = merged_b;
      mask_d  = ~(4'b0111 >> idx_q);
      last_d  = pix_last;
      vq_d    = 1'b1;
      idx_d   = 2'd0;
      acc_r_d = {3{PAD_VALUE}};
      acc_g_d = {3{PAD_VALUE}};
      acc_b_d = {3{PAD_VALUE}};
    end else if (accept) begin
      idx_d   = idx_q + 2'd1;
      acc_r_d = merged_r[QUAD_W-1:PIX_W];
      acc_g_d = merged_g[QUAD_W-1:PIX_W];
      acc_b_d = merged_b[QUAD_W-1:PIX_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'd0;
      acc_r_q <= {3{PAD_VALUE}};
      acc_g_q <= {3{PAD_VALUE}};
      acc_b_q <= {3{PAD_VALUE}};
      out_r_q <= '0;
      out_g_q <= '0;
      out_b_q <= '0;
      mask_q  <= 4'b0000;
      last_q  <= 1'b0;
      vq_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      acc_r_q <= acc_r_d;
      acc_g_q <= acc_g_d;
      acc_b_q <= acc_b_d;
      out_r_q <= out_r_d;
      out_g_q <= out_g_d;
      out_b_q <= out_b_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      vq_q    <= vq_d;
    end
  end

  assign valid_quad = vq_q;
  assign R_quad     = out_r_q;
  assign G_quad     = out_g_q;
  assign B_quad     = out_b_q;
  assign quad_mask  = mask_q;
  assign quad_last  = last_q;

`ifdef PACKER_COUNT_EN
  logic [15:0] qcnt_q, lcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt_q <= 16'd0;
      lcnt_q <= 16'd0;
    end else if (vq_q && quad_ready) begin
      qcnt_q <= qcnt_q + 16'd1;
      if (last_q) begin
        lcnt_q <= lcnt_q + 16'd1;
      end
    end
  end

  assign quad_count = qcnt_q;
  assign line_count = lcnt_q;
`endif

endmodule

`default_nettype wire
